alu_mul_seq: RTL and testbench

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

---
 rtl/alu_mul_seq.sv | 91 +++++++++
 tb/tb_alu_mul_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential 64x64 unsigned shift-add multiplier. Borrows an external
// combinational ALU for the 64-bit add, one partial product per cycle.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product_hi,
    output logic [63:0] product_lo,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_cntrl,
    input  logic [63:0] alu_result,
    input  logic        alu_carry_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b000;

    state_t      state, state_nxt;
    logic [5:0]  count;
    logic [63:0] mcand;
    logic [63:0] acc_hi;
    logic [63:0] acc_lo;
    logic        accept;
    logic        last_iter;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == RUN) && (count == 6 'd63);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == 6'd63) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The 129-bit ALU sum shifted right by one: the carry becomes the new
    // top bit and the dropped sum LSB enters the low accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (accept) begin
            count  <= '0;
            mcand  <= multiplicand;
            acc_hi <= '0;
            acc_lo <= multiplier;
        end else if (state == RUN) begin
            count  <= last_iter ? 6'd0 : count + 6'd1;
            acc_hi <= {alu_carry_out, alu_result[63:1]};
            acc_lo <= {alu_result[0], acc_lo[63:1]};
        end
    end

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_cntrl = ALU_NONE;
        if (state == RUN) begin
            alu_a     = acc_hi;
            alu_b     = acc_lo[0] ? mcand : 64'd0;
            alu_cntrl = ALU_ADD;
        end
    end

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign product_hi = acc_hi;
    assign product_lo = acc_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU model attached.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product_hi;
    logic [63:0] product_lo;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_cntrl;
    logic [63:0] alu_result;
    logic        alu_carry_out;
    logic [64:0] alu_sum;

    int checks = 0;
    int fails  = 0;
    bit saw_carry;

    always #5 clk = ~clk;

    // ALU: 010 is add with carry-in 0; other codes are unused by the DUT.
    always_comb begin
        alu_sum = '0;
        if (alu_cntrl == 3'b010) alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_result    = alu_sum[63:0];
    assign alu_carry_out = alu_sum[64];

    always @(posedge clk) if (busy && alu_carry_out) saw_carry = 1'b1;

    alu_mul_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done),
        .product_hi(product_hi), .product_lo(product_lo),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    // Called one step after the accepting edge; returns edges until done.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int nb;
        int nbad;
        int d_cnt;
        int last;
        int first;
        int gap_bad;

        reset = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_prod", {product_hi, product_lo}, 128'd0);
        chk("rst_alu", {alu_a, alu_b, alu_cntrl}, '0);
        reset = 1'b0;
        step();

        // 3*5: busy for exactly 64 cycles, one-cycle done, product held
        launch(64'd3, 64'd5);
        nb = busy ? 1 : 0;
        for (int i = 1; i < 64; i++) begin
            step();
            if (busy === 1'b1) nb++;
        end
        chk("busy_cycles", nb, 64);
        step();
        chk("t1_done", {done, busy}, 2'b10);
        chk("t1_prod", {product_hi, product_lo}, {64'd0, 64'd15});
        step();
        chk("t1_done_pulse", done, 1'b0);
        repeat (5) step();
        chk("t1_hold", {product_hi, product_lo}, {64'd0, 64'd15});

        // all ones squared exercises the ALU carry
        saw_carry = 1'b0;
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(cyc);
        chk("t2_lat", cyc, 64);
        chk("t2_prod", {product_hi, product_lo},
            {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
        chk("t2_carry", saw_carry, 1'b1);
        step();

        // zero multiplier: every partial product is zero
        launch(64'h1234, 64'd0);
        cyc = 0; nbad = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (alu_b !== 64'd0 || alu_cntrl !== 3'b010) nbad++;
            step();
            cyc++;
        end
        chk("t3_run_len", cyc, 64);
        chk("t3_alu_bad", nbad, 0);
        chk("t3_done", done, 1'b1);
        chk("t3_prod", {product_hi, product_lo}, 128'd0);
        chk("t3_idle_alu", {alu_a, alu_b, alu_cntrl}, '0);
        step();

        // start re-asserted mid-run must be ignored
        launch(64'h100, 64'h200);
        repeat (9) step();
        multiplicand = 64'd7; multiplier = 64'd7; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 10;
        while (done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t4_lat", cyc, 64);
        chk("t4_prod", {product_hi, product_lo}, {64'd0, 64'h20000});
        step();

        // wide operands crossing into the high word
        launch(64'h8000_0000_0000_0000, 64'd4);
        wait_done(cyc);
        chk("t5_prod", {product_hi, product_lo}, {64'd2, 64'd0});
        step();
        launch(64'hFFFF_FFFF, 64'hFFFF_FFFF);
        wait_done(cyc);
        chk("t5b_prod", {product_hi, product_lo}, {64'd0, 64'hFFFF_FFFE_0000_0001});
        step();

        // asynchronous reset at RUN cycle 30
        launch(64'hDEAD, 64'hBEEF);
        repeat (29) step();
        reset = 1'b1;
        #1;
        chk("t6_busy", {busy, done}, 2'b00);
        chk("t6_prod", {product_hi, product_lo}, 128'd0);
        chk("t6_alu", {alu_a, alu_b, alu_cntrl}, '0);
        step();
        reset = 1'b0;
        step();
        launch(64'd7, 64'd9);
        wait_done(cyc);
        chk("t6_lat", cyc, 64);
        chk("t6_prod_after", {product_hi, product_lo}, {64'd0, 64'd63});
        step();

        // start held high: DONE then IDLE before each new acceptance,
        // so completions are 66 edges apart
        multiplicand = 64'd3; multiplier = 64'd5; start = 1'b1;
        step();
        d_cnt = 0; last = -1; first = -1; gap_bad = 0;
        for (int c = 0; c < 200; c++) begin
            if (done === 1'b1) begin
                d_cnt++;
                if (first < 0) first = c;
                if (last >= 0 && c - last != 66) gap_bad++;
                if (product_lo !== 64'd15 || product_hi !== 64'd0) gap_bad++;
                last = c;
            end
            step();
        end
        chk("t7_first_done", first, 64);
        chk("t7_done_count", d_cnt, 3);
        chk("t7_gap_bad", gap_bad, 0);
        start = 1'b0;
        cyc = 0;
        while ((busy === 1'b1 || done === 1'b1) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t7_drain", {busy, done}, 2'b00);
        chk("t7_final_prod", {product_hi, product_lo}, {64'd0, 64'd15});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
